// File: rtl/wash_timer_unit.sv
// Two independent IDLE/RUN/DONE interval timers; TnDone rises Tn_TICKS*PRESCALE edges after Start is sampled in IDLE.
// Optional Pause input (freezes channels in RUN) exists only when WASH_TIMER_PAUSE_EN is defined.
module wash_timer_chan #(
    parameter int PRESCALE = 10,
    parameter int TICKS    = 5,
    parameter int CNT_W    = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
`ifdef WASH_TIMER_PAUSE_EN
    input  logic i_pause,
`endif
    output logic o_done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] TICK_LOAD = CNT_W'(TICKS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_pre;
    logic [CNT_W-1:0] r_tick;
    logic             r_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_tick  <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_pre   <= PRE_LOAD;
                        r_tick  <= TICK_LOAD;
                    end
                    r_done <= 1'b0;
                end
                S_RUN: begin
                    // Abort takes priority over both pause and expiry.
                    if (!i_start) begin
                        r_state <= S_IDLE;
                        r_pre   <= '0;
                        r_tick  <= '0;
                        r_done  <= 1'b0;
`ifdef WASH_TIMER_PAUSE_EN
                    end else if (i_pause) begin
                        r_done <= 1'b0;
`endif
                    end else if (r_pre == '0) begin
                        r_pre <= PRE_LOAD;
                        if (r_tick == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_tick <= r_tick - 1'b1;
                            r_done <= 1'b0;
                        end
                    end else begin
                        r_pre  <= r_pre - 1'b1;
                        r_done <= 1'b0;
                    end
                end
                S_DONE: begin
                    // No retrigger: Start must drop for an edge before a new interval.
                    if (!i_start) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pre   <= '0;
                    r_tick  <= '0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_done = r_done;
endmodule

module wash_timer_unit #(
    parameter int PRESCALE = 10,
    parameter int T1_TICKS = 5,
    parameter int T2_TICKS = 20,
    parameter int CNT_W    = 16
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic T1Start,
    input  logic T2Start,
`ifdef WASH_TIMER_PAUSE_EN
    input  logic Pause,
`endif
    output logic T1Done,
    output logic T2Done
);
    logic w_t1_done;
    logic w_t2_done;

    wash_timer_chan #(.PRESCALE(PRESCALE), .TICKS(T1_TICKS), .CNT_W(CNT_W)) u_t1 (
        .i_clk   (CLOCK),
        .i_rst   (RESET),
        .i_start (T1Start),
`ifdef WASH_TIMER_PAUSE_EN
        .i_pause (Pause),
`endif
        .o_done  (w_t1_done)
    );

    wash_timer_chan #(.PRESCALE(PRESCALE), .TICKS(T2_TICKS), .CNT_W(CNT_W)) u_t2 (
        .i_clk   (CLOCK),
        .i_rst   (RESET),
        .i_start (T2Start),
`ifdef WASH_TIMER_PAUSE_EN
        .i_pause (Pause),
`endif
        .o_done  (w_t2_done)
    );

    assign T1Done = w_t1_done;
    assign T2Done = w_t2_done;
endmodule

// File: tb/tb_wash_timer_unit.sv
// Directed bench for wash_timer_unit with PRESCALE=2, T1_TICKS=3, T2_TICKS=5 (T1 expires 6 edges, T2 10 edges after sampling).
module tb_wash_timer_unit;
    logic CLOCK = 1'b0;
    logic RESET;
    logic T1Start;
    logic T2Start;
    logic T1Done;
    logic T2Done;
`ifdef WASH_TIMER_PAUSE_EN
    logic Pause;
`endif

    int checks = 0;
    int errors = 0;

    wash_timer_unit #(.PRESCALE(2), .T1_TICKS(3), .T2_TICKS(5), .CNT_W(16)) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .T1Start (T1Start),
        .T2Start (T2Start),
`ifdef WASH_TIMER_PAUSE_EN
        .Pause   (Pause),
`endif
        .T1Done  (T1Done),
        .T2Done  (T2Done)
    );

    always #5 CLOCK = ~CLOCK;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic go_idle();
        T1Start = 1'b0;
        T2Start = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        RESET   = 1'b1;
        T1Start = 1'b0;
        T2Start = 1'b0;
`ifdef WASH_TIMER_PAUSE_EN
        Pause   = 1'b0;
`endif
        #2;
        checks++;
        if (T1Done !== 1'b0) begin errors++; $display("FAIL reset_t1 got %b exp 0", T1Done); end
        checks++;
        if (T2Done !== 1'b0) begin errors++; $display("FAIL reset_t2 got %b exp 0", T2Done); end
        T1Start = 1'b1;
        step();
        step();
        checks++;
        if (T1Done !== 1'b0) begin errors++; $display("FAIL reset_held_t1 got %b exp 0", T1Done); end
        T1Start = 1'b0;
        RESET = 1'b0;
        step();
    endtask

    task automatic test_t1_only();
        T1Start = 1'b1;
        step();
        for (int k = 1; k <= 9; k++) begin
            step();
            checks++;
            if (T1Done !== (k >= 6)) begin errors++; $display("FAIL t1_only_done edge %0d got %b exp %b", k, T1Done, (k >= 6)); end
            checks++;
            if (T2Done !== 1'b0) begin errors++; $display("FAIL t1_only_t2 edge %0d got %b exp 0", k, T2Done); end
        end
        T1Start = 1'b0;
        step();
        checks++;
        if (T1Done !== 1'b0) begin errors++; $display("FAIL t1_only_clear got %b exp 0", T1Done); end
        go_idle();
    endtask

    task automatic test_both();
        T1Start = 1'b1;
        T2Start = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (T1Done !== (k >= 6)) begin errors++; $display("FAIL both_t1 edge %0d got %b exp %b", k, T1Done, (k >= 6)); end
            checks++;
            if (T2Done !== (k >= 10)) begin errors++; $display("FAIL both_t2 edge %0d got %b exp %b", k, T2Done, (k >= 10)); end
        end
        T1Start = 1'b0;
        step();
        checks++;
        if (T1Done !== 1'b0) begin errors++; $display("FAIL both_drop_t1 got %b exp 0", T1Done); end
        checks++;
        if (T2Done !== 1'b1) begin errors++; $display("FAIL both_keep_t2 got %b exp 1", T2Done); end
        T2Start = 1'b0;
        step();
        checks++;
        if (T2Done !== 1'b0) begin errors++; $display("FAIL both_drop_t2 got %b exp 0", T2Done); end
        go_idle();
    endtask

    task automatic test_abort();
        T2Start = 1'b1;
        step();
        for (int k = 1; k <= 3; k++) step();
        T2Start = 1'b0;
        for (int k = 4; k <= 12; k++) begin
            step();
            checks++;
            if (T2Done !== 1'b0) begin errors++; $display("FAIL abort_t2 edge %0d got %b exp 0", k, T2Done); end
        end
        T2Start = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (T2Done !== (k >= 10)) begin errors++; $display("FAIL abort_restart_t2 edge %0d got %b exp %b", k, T2Done, (k >= 10)); end
        end
        go_idle();
        // Start falls on the very edge that would expire the interval.
        T1Start = 1'b1;
        step();
        for (int k = 1; k <= 5; k++) step();
        T1Start = 1'b0;
        for (int k = 6; k <= 8; k++) begin
            step();
            checks++;
            if (T1Done !== 1'b0) begin errors++; $display("FAIL abort_at_expiry edge %0d got %b exp 0", k, T1Done); end
        end
        go_idle();
    endtask

    task automatic test_reset_mid_run();
        T1Start = 1'b1;
        step();
        for (int k = 1; k <= 3; k++) step();
        #2 RESET = 1'b1;
        #1;
        checks++;
        if (T1Done !== 1'b0) begin errors++; $display("FAIL rst_run_async got %b exp 0", T1Done); end
        step();
        RESET = 1'b0;
        step();
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (T1Done !== (k >= 6)) begin errors++; $display("FAIL rst_run_restart edge %0d got %b exp %b", k, T1Done, (k >= 6)); end
        end
        // Reset while in DONE must clear the output without a clock edge.
        #2 RESET = 1'b1;
        #1;
        checks++;
        if (T1Done !== 1'b0) begin errors++; $display("FAIL rst_done_async got %b exp 0", T1Done); end
        step();
        RESET = 1'b0;
        step();
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (T1Done !== (k >= 6)) begin errors++; $display("FAIL rst_done_restart edge %0d got %b exp %b", k, T1Done, (k >= 6)); end
        end
        go_idle();
    endtask

    task automatic test_hold_done();
        T1Start = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) step();
        checks++;
        if (T1Done !== 1'b1) begin errors++; $display("FAIL hold_reach got %b exp 1", T1Done); end
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (T1Done !== 1'b1) begin errors++; $display("FAIL hold_done edge %0d got %b exp 1", k, T1Done); end
        end
        T1Start = 1'b0;
        step();
        checks++;
        if (T1Done !== 1'b0) begin errors++; $display("FAIL hold_gap got %b exp 0", T1Done); end
        T1Start = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (T1Done !== (k >= 6)) begin errors++; $display("FAIL hold_rerun edge %0d got %b exp %b", k, T1Done, (k >= 6)); end
        end
        go_idle();
    endtask

`ifdef WASH_TIMER_PAUSE_EN
    task automatic test_pause();
        T1Start = 1'b1;
        step();
        for (int k = 1; k <= 11; k++) begin
            Pause = (k >= 3 && k <= 6);
            step();
            checks++;
            if (T1Done !== (k >= 10)) begin errors++; $display("FAIL pause_t1 edge %0d got %b exp %b", k, T1Done, (k >= 10)); end
        end
        Pause = 1'b0;
        go_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_t1_only();
        test_both();
        test_abort();
        test_reset_mid_run();
        test_hold_done();
`ifdef WASH_TIMER_PAUSE_EN
        test_pause();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wash_timer_unit.md
WASH_TIMER_UNIT -- requirements
Module: wash_timer_unit

Interface
REQ-001 Parameter: PRESCALE, 10, clock cycles per timer tick (>=1).
REQ-002 Parameter: T1_TICKS, 5, ticks per T1 interval, the agitate/soak phase (>=1).
REQ-003 Parameter: T2_TICKS, 20, ticks per T2 interval, the total wash/rinse duration (>=1).
REQ-004 Parameter: CNT_W, 16, width of the tick and prescale counters; T1_TICKS, T2_TICKS and PRESCALE SHALL each fit in CNT_W bits.
REQ-005 Port: CLOCK  input  1  single clock, rising-edge active.
REQ-006 Port: RESET  input  1  asynchronous, active-high reset.
REQ-007 Port: T1Start  input  1  level request for the T1 interval, from the washing machine controller.
REQ-008 Port: T2Start  input  1  level request for the T2 interval, from the washing machine controller.
REQ-009 Port: T1Done  output  1  T1 interval expired, registered.
REQ-010 Port: T2Done  output  1  T2 interval expired, registered.
REQ-011 Port (present only with WASH_TIMER_PAUSE_EN): Pause  input  1  freezes both timers.

Function
REQ-012 The block SHALL contain two identical, fully independent timer channels (T1, T2), each with its own FSM, prescale counter and tick counter.
REQ-013 Each channel FSM SHALL have states IDLE, RUN and DONE.
REQ-014 IDLE with Start=1 at a rising edge -> RUN; on that edge the prescale counter loads PRESCALE-1 and the tick counter loads Tn_TICKS-1.
REQ-015 In RUN with Start=1, the prescale counter SHALL decrement by one each edge.
REQ-016 In RUN, when the prescale counter is 0, it SHALL reload PRESCALE-1; if the tick counter is also 0 the FSM SHALL go to DONE, otherwise the tick counter SHALL decrement.
REQ-017 Latency: Done SHALL be high immediately after the (Tn_TICKS*PRESCALE)th rising edge following the edge that sampled Start in IDLE.
REQ-018 RUN with Start=0 -> IDLE (abort); Done stays 0.
REQ-019 If Start falls on the same edge as expiry, abort SHALL win: -> IDLE, Done never asserted.
REQ-020 DONE with Start=1 SHALL hold DONE; there is no retrigger while Start stays high.
REQ-021 DONE with Start=0 -> IDLE; Done SHALL clear after that edge.
REQ-022 A new interval SHALL start only from IDLE, so Start must be low for at least one edge between intervals.
REQ-023 TnDone SHALL equal (state==DONE), driven directly from a flop, with no combinational path from any input.
REQ-024 Simultaneous T1Start and T2Start activity SHALL NOT interact; each channel SHALL behave exactly as it would alone.

Reset
REQ-025 RESET=1 SHALL immediately force both FSMs to IDLE, all counters to 0, and T1Done=T2Done=0, independent of CLOCK.
REQ-026 Reset mid-RUN or in DONE SHALL discard progress; after RESET=0, a held Start SHALL begin a fresh full interval on the next edge.

Configuration
REQ-027 Macro WASH_TIMER_PAUSE_EN defined: the Pause port exists; while Pause=1, channels in RUN SHALL hold both counters and state, abort (Start=0) SHALL still apply, and latency SHALL extend by exactly the number of paused edges.
REQ-028 Macro WASH_TIMER_PAUSE_EN undefined: no Pause port and no pause logic; behaviour SHALL be per REQ-012..REQ-026.

Verification (PRESCALE=2, T1_TICKS=3, T2_TICKS=5, 10 ns clock)
REQ-029 Release RESET, T1Start=1 held -> T1Done rises exactly 6 edges after the sampling edge and stays high; T2Done=0 throughout.
REQ-030 T1Start and T2Start raised on the same edge -> T1Done rises at edge 6 and T2Done at edge 10; dropping T1Start clears only T1Done on the next edge.
REQ-031 T2Start dropped at edge 4 -> T2Done never rises; re-raising it afterwards gives T2Done 10 edges later.
REQ-032 RESET pulsed mid-RUN at edge 3 with T1Start held -> T1Done=0 asynchronously; T1Done rises 6 edges after the first edge following reset release.
REQ-033 Start held high through DONE for 20 edges -> Done stays 1 with no retrigger; Start low for 1 edge, then high -> new full interval.
REQ-034 With WASH_TIMER_PAUSE_EN, Pause=1 for 4 edges during T1 RUN -> T1Done rises at edge 10 instead of edge 6.
